// File: rtl/wb_sched.sv
// wb_sched: register-file writeback scheduler merging pipeline writes with a one-entry multiplier buffer.
// Optional build macro WB_FAIR_ARB_EN: a result held for STARVE_MAX cycles overrides pipeline writeback.
module wb_sched #(
  parameter int width      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_valid,
  input  logic [4:0]       pipe_rd,
  input  logic [1:0]       pipe_sel,
  output logic [1:0]       selectLine,
  input  logic [width-1:0] dataW,
  output logic             pipe_stall,
  input  logic             mul_valid,
  input  logic [4:0]       mul_rd,
  input  logic [width-1:0] mul_result,
  output logic             mul_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [width-1:0] rf_wdata
);
  localparam logic EMPTY = 1'b0;
  localparam logic HELD  = 1'b1;

  logic             r_state;
  logic [4:0]       r_buf_rd;
  logic [width-1:0] r_buf_data;
  logic             w_held;
  logic             w_mul_grant;
  logic             w_pipe_grant;
  logic             w_xfer;
  logic             w_we;

  assign selectLine   = pipe_sel;
  assign w_held       = (r_state == HELD);
  assign mul_ready    = !w_held || w_mul_grant;
  assign w_xfer       = mul_valid && mul_ready;
  assign w_pipe_grant = pipe_valid && !w_mul_grant;
  // A grant to register 0 is consumed (buffer drains / pipeline advances) but never writes.
  assign w_we         = (w_mul_grant && (r_buf_rd != 5'd0)) || (w_pipe_grant && (pipe_rd != 5'd0));

`ifdef WB_FAIR_ARB_EN
  localparam logic [2:0] L_STARVE_MAX = 3'(STARVE_MAX);
  logic [2:0] r_starve_cnt;

  assign w_mul_grant = w_held && (!pipe_valid || (r_starve_cnt >= L_STARVE_MAX));
  assign pipe_stall  = pipe_valid && w_mul_grant;

  // Count cycles a held result loses arbitration; saturates at 7, clears when EMPTY or granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_starve_cnt <= 3'd0;
    else if (!w_held || w_mul_grant)
      r_starve_cnt <= 3'd0;
    else if (r_starve_cnt != 3'd7)
      r_starve_cnt <= r_starve_cnt + 3'd1;
  end
`else
  logic w_unused;

  assign w_unused    = (STARVE_MAX != 0);
  assign w_mul_grant = w_held && !pipe_valid;
  assign pipe_stall  = 1'b0;
`endif

  // Buffer FSM: a transfer always (re)fills the entry; a grant without refill empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_buf_rd   <= 5'd0;
      r_buf_data <= '0;
    end else if (w_xfer) begin
      r_state    <= HELD;
      r_buf_rd   <= mul_rd;
      r_buf_data <= mul_result;
    end else if (w_mul_grant) begin
      r_state    <= EMPTY;
    end
  end

  // Registered write port; address and data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_we <= w_we;
      if (w_mul_grant) begin
        rf_waddr <= r_buf_rd;
        rf_wdata <= r_buf_data;
      end else if (w_pipe_grant) begin
        rf_waddr <= pipe_rd;
        rf_wdata <= dataW;
      end
    end
  end
endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed checks of wb_sched arbitration, latency, register-0 filter and reset.
module tb_wb_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [1:0]  pipe_sel;
  logic [1:0]  selectLine;
  logic [31:0] dataW;
  logic        pipe_stall;
  logic        mul_valid;
  logic [4:0]  mul_rd;
  logic [31:0] mul_result;
  logic        mul_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int n_chk = 0;
  int n_err = 0;

  wb_sched #(.width(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_valid(pipe_valid), .pipe_rd(pipe_rd),
    .pipe_sel(pipe_sel), .selectLine(selectLine), .dataW(dataW),
    .pipe_stall(pipe_stall), .mul_valid(mul_valid), .mul_rd(mul_rd),
    .mul_result(mul_result), .mul_ready(mul_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pipe_valid = 1'b0; pipe_rd = 5'd0; pipe_sel = 2'b00; dataW = '0;
    mul_valid = 1'b0; mul_rd = 5'd0; mul_result = '0;
    #12;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ready", mul_ready, 1);
    chk("rst_stall", pipe_stall, 0);
    rst_n = 1'b1;
    tick;
    for (int s = 0; s < 4; s++) begin
      pipe_sel = 2'(s);
      #1 chk("sel", selectLine, 64'(s));
    end
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_sel = 2'b01; dataW = 32'hAAAAAAAA;
    #1 chk("p_sel", selectLine, 1);
    chk("p_stall", pipe_stall, 0);
    tick;
    chk("p_we", rf_we, 1);
    chk("p_waddr", rf_waddr, 5);
    chk("p_wdata", rf_wdata, 32'hAAAAAAAA);
    pipe_valid = 1'b0; dataW = 32'h0;
    tick;
    chk("idle_we", rf_we, 0);
    chk("idle_waddr", rf_waddr, 5);
    chk("idle_wdata", rf_wdata, 32'hAAAAAAAA);
    mul_valid = 1'b1; mul_rd = 5'd7; mul_result = 32'h12345678;
    #1 chk("m_ready0", mul_ready, 1);
    tick;
    mul_valid = 1'b0;
    #1 chk("m_ready1", mul_ready, 1);
    chk("m_we_early", rf_we, 0);
    tick;
    chk("m_we", rf_we, 1);
    chk("m_waddr", rf_waddr, 7);
    chk("m_wdata", rf_wdata, 32'h12345678);
    tick;
    chk("m_empty_we", rf_we, 0);
    chk("m_empty_ready", mul_ready, 1);
    mul_valid = 1'b1; mul_rd = 5'd9; mul_result = 32'hCAFEF00D;
    tick;
    mul_valid = 1'b0; pipe_valid = 1'b1; pipe_rd = 5'd3;
`ifdef WB_FAIR_ARB_EN
    for (int i = 0; i < 4; i++) begin
      dataW = 32'(i + 100);
      #1 chk("s_stall", pipe_stall, 0);
      chk("s_ready", mul_ready, 0);
      tick;
      chk("s_pwaddr", rf_waddr, 3);
      chk("s_pwdata", rf_wdata, 64'(i + 100));
    end
    #1 chk("s_stall5", pipe_stall, 1);
    chk("s_ready5", mul_ready, 1);
    tick;
    chk("s_mwe", rf_we, 1);
    chk("s_mwaddr", rf_waddr, 9);
    chk("s_mwdata", rf_wdata, 32'hCAFEF00D);
    #1 chk("s_stall_after", pipe_stall, 0);
    tick;
    chk("s_pwaddr_after", rf_waddr, 3);
`else
    for (int i = 0; i < 6; i++) begin
      dataW = 32'(i + 100);
      #1 chk("s_stall", pipe_stall, 0);
      chk("s_ready", mul_ready, 0);
      tick;
      chk("s_pwaddr", rf_waddr, 3);
      chk("s_pwdata", rf_wdata, 64'(i + 100));
    end
    pipe_valid = 1'b0;
    #1 chk("s_ready_idle", mul_ready, 1);
    tick;
    chk("s_mwe", rf_we, 1);
    chk("s_mwaddr", rf_waddr, 9);
    chk("s_mwdata", rf_wdata, 32'hCAFEF00D);
`endif
    pipe_valid = 1'b0;
    tick;
    mul_valid = 1'b1; mul_rd = 5'd10; mul_result = 32'h11111111;
    #1 chk("b_ready0", mul_ready, 1);
    tick;
    mul_rd = 5'd11; mul_result = 32'h22222222;
    #1 chk("b_ready1", mul_ready, 1);
    tick;
    mul_valid = 1'b0;
    chk("b_we1", rf_we, 1);
    chk("b_waddr1", rf_waddr, 10);
    chk("b_wdata1", rf_wdata, 32'h11111111);
    tick;
    chk("b_we2", rf_we, 1);
    chk("b_waddr2", rf_waddr, 11);
    chk("b_wdata2", rf_wdata, 32'h22222222);
    tick;
    chk("b_we3", rf_we, 0);
    pipe_valid = 1'b1; pipe_rd = 5'd0; dataW = 32'hDEADBEEF;
    tick;
    chk("z_pwe", rf_we, 0);
    pipe_valid = 1'b0;
    mul_valid = 1'b1; mul_rd = 5'd0; mul_result = 32'hBEEFBEEF;
    tick;
    mul_valid = 1'b0;
    #1 chk("z_mready", mul_ready, 1);
    tick;
    chk("z_mwe", rf_we, 0);
    tick;
    chk("z_empty_ready", mul_ready, 1);
    mul_valid = 1'b1; mul_rd = 5'd12; mul_result = 32'h55555555;
    pipe_valid = 1'b1; pipe_rd = 5'd4; dataW = 32'h44444444;
    tick;
    mul_valid = 1'b0;
    #1 chk("r_held_ready", mul_ready, 0);
    rst_n = 1'b0;
    pipe_valid = 1'b0;
    #1 chk("r_we", rf_we, 0);
    chk("r_waddr", rf_waddr, 0);
    chk("r_wdata", rf_wdata, 0);
    chk("r_ready", mul_ready, 1);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("r_post_we", rf_we, 0);
      chk("r_post_wdata", rf_wdata, 0);
      chk("r_post_ready", mul_ready, 1);
      chk("r_post_stall", pipe_stall, 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
